// File: rtl/rv_seq_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
// Latency: none; this file holds only types, constants and a pure decode function.
// Backpressure: not applicable.
package rv_seq_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_ALU    = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JUMP   = 3'd5,
        CL_UPPER  = 3'd6
    } class_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // CL_NONE doubles as "not an RV32I base opcode we sequence" -> illegal.
    function automatic class_t classify(input logic [6:0] opcode);
        class_t cl;
        case (opcode)
            OP_REG, OP_IMM:    cl = CL_ALU;
            OP_LOAD:           cl = CL_LOAD;
            OP_STORE:          cl = CL_STORE;
            OP_BRANCH:         cl = CL_BRANCH;
            OP_JAL, OP_JALR:   cl = CL_JUMP;
            OP_LUI, OP_AUIPC:  cl = CL_UPPER;
            default:           cl = CL_NONE;
        endcase
        return cl;
    endfunction

endpackage

// File: rtl/rv_seq_timeout.sv
// Memory-request watchdog: counts request cycles that go unacknowledged.
// Latency: o_expired is a registered-count compare, valid in the cycle the count reaches MEM_TIMEOUT-1.
// Backpressure: none; clear has priority over enable.
module rv_seq_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt;

    // Count waiting cycles; the owner stops the count by trapping at LIMIT, so no wrap handling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 8'd0;
        end else if (i_clr) begin
            cnt <= 8'd0;
        end else if (i_en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign o_expired = (cnt == LIMIT);

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle RV32I sequencer gating PC/IR/regfile/memory-port updates; optional perf counters under RV_SEQ_CTRL_PERF_EN.
// Latency (zero-wait memory): ALU/UPPER/JUMP 4, BRANCH 3, STORE 4, LOAD 5 cycles; each ack delay cycle adds one.
// Backpressure: FETCH/MEM hold o_mem_req until i_mem_ack; MEM_TIMEOUT unacked cycles trap until reset.
module rv_seq_ctrl
    import rv_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_br_taken,
    input  logic        i_mem_ack,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_addr_sel,
    output logic        o_ir_wren,
    output logic        o_pc_wren,
    output logic        o_pc_sel,
    output logic        o_rd_wren,
    output logic        o_insn_vld,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [2:0]  o_state
`ifdef RV_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_retire_cnt
`endif
);

    state_t     state_q, state_d;
    class_t     class_q, class_d;
    logic [1:0] cause_q, cause_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    // Only the opcode field steers sequencing; the rest of the IR belongs to the datapath decoder.
    logic unused_instr_bits;
    assign unused_instr_bits = ^i_instr[31:7];

    // Request is a pure state decode so an async reset drops it immediately.
    assign o_mem_req    = (state_q == S_FETCH) || (state_q == S_MEM);
    assign o_trap       = (state_q == S_TRAP);
    assign o_trap_cause = cause_q;
    assign o_state      = state_q;

    // Idle cycles, and any ack, restart the watchdog so each FETCH/MEM visit gets a full budget.
    assign tmo_clr = !o_mem_req || i_mem_ack;
    assign tmo_en  = o_mem_req && !i_mem_ack;

    rv_seq_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (tmo_clr),
        .i_en      (tmo_en),
        .o_expired (tmo_expired)
    );

    // State, instruction class and trap cause registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_RST;
            class_q <= CL_NONE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and datapath enables; ack in the last allowed cycle beats the timeout.
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        cause_d    = cause_q;
        o_mem_we   = 1'b0;
        o_addr_sel = 1'b0;
        o_ir_wren  = 1'b0;
        o_pc_wren  = 1'b0;
        o_pc_sel   = 1'b0;
        o_rd_wren  = 1'b0;
        o_insn_vld = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (i_mem_ack) begin
                    o_ir_wren = 1'b1;
                    state_d   = S_DECODE;
                end else if (tmo_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                class_d = classify(i_instr[6:0]);
                if (class_d == CL_NONE) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    CL_BRANCH: begin
                        o_pc_wren  = 1'b1;
                        o_pc_sel   = i_br_taken;
                        o_insn_vld = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                o_addr_sel = 1'b1;
                o_mem_we   = (class_q == CL_STORE);
                if (i_mem_ack) begin
                    if (class_q == CL_STORE) begin
                        o_pc_wren  = 1'b1;
                        o_insn_vld = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                o_rd_wren  = 1'b1;
                o_pc_wren  = 1'b1;
                o_pc_sel   = (class_q == CL_JUMP);
                o_insn_vld = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

`ifdef RV_SEQ_CTRL_PERF_EN
    // Active-cycle and retired-instruction counters, free-running modulo 2^32.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycle_cnt  <= 32'd0;
            o_retire_cnt <= 32'd0;
        end else begin
            if ((state_q != S_RST) && (state_q != S_TRAP)) begin
                o_cycle_cnt <= o_cycle_cnt + 32'd1;
            end
            if (o_insn_vld) begin
                o_retire_cnt <= o_retire_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Scoreboard bench for rv_seq_ctrl: random instruction stream with randomized memory latency.
// Latency: expected retire/trap cycle computed per instruction from the per-class cycle budget.
// Backpressure: bench memory acks after a chosen delay; delays >= MEM_TIMEOUT exercise the trap.
module tb_rv_seq_ctrl;

    localparam int T = 4;

    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam int C_ILL = 0, C_ALU = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JMP = 5, C_UP = 6;

    logic        i_clk, i_rst_n, i_br_taken, i_mem_ack;
    logic [31:0] i_instr;
    logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_wren, o_pc_wren, o_pc_sel;
    logic        o_rd_wren, o_insn_vld, o_trap;
    logic [1:0]  o_trap_cause;
    logic [2:0]  o_state;
`ifdef RV_SEQ_CTRL_PERF_EN
    logic [31:0] o_cycle_cnt, o_retire_cnt;
`endif

    rv_seq_ctrl #(.MEM_TIMEOUT(T)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_instr      (i_instr),
        .i_br_taken   (i_br_taken),
        .i_mem_ack    (i_mem_ack),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_addr_sel   (o_addr_sel),
        .o_ir_wren    (o_ir_wren),
        .o_pc_wren    (o_pc_wren),
        .o_pc_sel     (o_pc_sel),
        .o_rd_wren    (o_rd_wren),
        .o_insn_vld   (o_insn_vld),
        .o_trap       (o_trap),
        .o_trap_cause (o_trap_cause),
        .o_state      (o_state)
`ifdef RV_SEQ_CTRL_PERF_EN
        ,
        .o_cycle_cnt  (o_cycle_cnt),
        .o_retire_cnt (o_retire_cnt)
`endif
    );

    typedef struct {
        bit         is_trap;
        int         cyc;
        bit         pc_sel;
        bit         rd;
        logic [1:0] cause;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc_no   = 0;
    bit   cur_st   = 0;
    bit   trap_seen;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc_no++;
        end
    end

    task automatic chkn(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chkn(nm, 32'(act), 32'(exp));
    endtask

    function automatic int cls_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h13: return C_ALU;
            7'h03:        return C_LD;
            7'h23:        return C_ST;
            7'h63:        return C_BR;
            7'h6F, 7'h67: return C_JMP;
            7'h37, 7'h17: return C_UP;
            default:      return C_ILL;
        endcase
    endfunction

    function automatic exp_t mk(input bit tr, input int c, input bit ps, input bit rd, input logic [1:0] ca);
        exp_t e;
        e.is_trap = tr; e.cyc = c; e.pc_sel = ps; e.rd = rd; e.cause = ca;
        return e;
    endfunction

    // One cycle of stimulus: check the state we expect to be in, drive ack, check Moore decodes mid-cycle.
    task automatic cyc(input bit a, input logic [2:0] st, input bit ir);
        chkn("state", 32'(o_state), 32'(st));
        i_mem_ack = a;
        @(negedge i_clk);
        chk1("ir_wren", o_ir_wren, ir);
        chk1("mem_req", o_mem_req, (st == ST_FETCH) || (st == ST_MEM));
        chk1("addr_sel", o_addr_sel, st == ST_MEM);
        chk1("mem_we", o_mem_we, (st == ST_MEM) && cur_st);
        chk1("rd_wren", o_rd_wren, st == ST_WB);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n   = 1'b0;
        i_mem_ack = 1'b0;
        #1;
        chkn("reset_outputs", 32'({o_mem_req, o_mem_we, o_addr_sel, o_ir_wren, o_pc_wren, o_pc_sel,
                                   o_rd_wren, o_insn_vld, o_trap, o_trap_cause, o_state}), 32'd0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        cur_st  = 1'b0;
        cyc(1'b0, ST_RST, 1'b0);
    endtask

    task automatic trap_hold();
        for (int k = 0; k < 3; k++) begin
            chkn("trap_state", 32'(o_state), 32'(ST_TRAP));
            i_mem_ack = (k != 1);
            @(negedge i_clk);
            chkn("trap_enables", 32'({o_mem_req, o_mem_we, o_ir_wren, o_pc_wren, o_rd_wren, o_insn_vld}), 32'd0);
            chk1("trap_flag", o_trap, 1'b1);
            @(posedge i_clk); #1;
        end
    endtask

    // Reference model: outcome and cycle offset from fetch start, per class and memory delays.
    task automatic run_insn(input logic [31:0] ins, input int df, input int dm, input bit bt);
        int c = cls_of(ins);
        int s = cyc_no;
        if (df >= T)                       q.push_back(mk(1, s + T, 0, 0, 2'b10));
        else if (c == C_ILL)               q.push_back(mk(1, s + df + 2, 0, 0, 2'b01));
        else if (c == C_BR)                q.push_back(mk(0, s + df + 2, bt, 0, 2'b00));
        else if (c == C_ALU || c == C_UP)  q.push_back(mk(0, s + df + 3, 0, 1, 2'b00));
        else if (c == C_JMP)               q.push_back(mk(0, s + df + 3, 1, 1, 2'b00));
        else if (dm >= T)                  q.push_back(mk(1, s + df + 3 + T, 0, 0, 2'b10));
        else if (c == C_ST)                q.push_back(mk(0, s + df + 3 + dm, 0, 0, 2'b00));
        else                               q.push_back(mk(0, s + df + 4 + dm, 0, 1, 2'b00));

        i_instr    = ins;
        cur_st     = (c == C_ST);
        i_br_taken = 1'($urandom_range(0, 1));
        if (df >= T) begin
            repeat (T) cyc(1'b0, ST_FETCH, 1'b0);
            trap_hold();
            do_reset();
            return;
        end
        repeat (df) cyc(1'b0, ST_FETCH, 1'b0);
        cyc(1'b1, ST_FETCH, 1'b1);
        cyc(1'b0, ST_DECODE, 1'b0);
        if (c == C_ILL) begin
            trap_hold();
            do_reset();
            return;
        end
        i_br_taken = bt;
        cyc(1'b0, ST_EXEC, 1'b0);
        i_br_taken = 1'($urandom_range(0, 1));
        if (c == C_BR) return;
        if (c == C_ALU || c == C_UP || c == C_JMP) begin
            cyc(1'b0, ST_WB, 1'b0);
            return;
        end
        if (dm >= T) begin
            repeat (T) cyc(1'b0, ST_MEM, 1'b0);
            trap_hold();
            do_reset();
            return;
        end
        repeat (dm) cyc(1'b0, ST_MEM, 1'b0);
        cyc(1'b1, ST_MEM, 1'b0);
        if (c == C_LD) cyc(1'b0, ST_WB, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every retire pulse and on trap entry; checks invariants each cycle.
    initial begin
        exp_t e;
        trap_seen = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                trap_seen = 1'b0;
            end else begin
                chk1("wren_exclusive", o_ir_wren && o_rd_wren, 1'b0);
                chk1("pc_wren_with_retire", o_pc_wren, o_insn_vld);
                if (o_insn_vld || (o_trap && !trap_seen)) begin
                    if (o_trap) trap_seen = 1'b1;
                    if (q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_event: retire=%0b trap=%0b with empty scoreboard (cycle %0d)",
                                 o_insn_vld, o_trap, cyc_no);
                    end else begin
                        e = q.pop_front();
                        chk1("event_kind_is_trap", o_trap, e.is_trap);
                        chkn("event_cycle", cyc_no, e.cyc);
                        if (e.is_trap) begin
                            chkn("trap_cause", 32'(o_trap_cause), 32'(e.cause));
                        end else begin
                            chk1("retire_pc_sel", o_pc_sel, e.pc_sel);
                            chk1("retire_rd_wren", o_rd_wren, e.rd);
                        end
                    end
                end
            end
        end
    end

    logic [6:0] ops [12];

    initial begin
        logic [31:0] ins;
        int df, dm;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00, 7'h7F, 7'h0F};
        i_rst_n    = 1'b1;
        i_mem_ack  = 1'b0;
        i_br_taken = 1'b0;
        i_instr    = 32'd0;
        #2;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        do_reset();

        run_insn(32'h00500093, 0, 0, 1'b0);   // ADDI
        run_insn(32'h0000A103, 0, 3, 1'b0);   // LW, ack on 4th MEM cycle
        run_insn(32'h00208463, 0, 0, 1'b1);   // BEQ taken
        run_insn(32'h00208463, 1, 0, 1'b0);   // BEQ not taken
        run_insn(32'h0000006F, 0, 0, 1'b0);   // JAL
        run_insn(32'h00112023, 2, 1, 1'b0);   // SW
        run_insn(32'h00000000, 0, 0, 1'b0);   // illegal
        run_insn(32'h00500093, 4, 0, 1'b0);   // fetch timeout
        run_insn(32'h00500093, 3, 0, 1'b0);   // ack exactly on last allowed cycle
        run_insn(32'h0000A103, 0, 4, 1'b0);   // MEM timeout

        // SW interrupted by reset while the store request is outstanding.
        i_instr = 32'h00112023;
        cur_st  = 1'b1;
        cyc(1'b1, ST_FETCH, 1'b1);
        cyc(1'b0, ST_DECODE, 1'b0);
        cyc(1'b0, ST_EXEC, 1'b0);
        cyc(1'b0, ST_MEM, 1'b0);
        chk1("sw_req_before_rst", o_mem_req, 1'b1);
        chk1("sw_we_before_rst", o_mem_we, 1'b1);
        do_reset();

        for (int n = 0; n < 150; n++) begin
            ins      = $urandom();
            ins[6:0] = ops[$urandom_range(0, 11)];
            df = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 2)) : int'($urandom_range(0, T - 1));
            dm = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 2)) : int'($urandom_range(0, T - 1));
            run_insn(ins, df, dm, 1'($urandom_range(0, 1)));
        end

        @(posedge i_clk); #1;
        chkn("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rv_seq_ctrl.md
Name: rv_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath when instruction fetch and data access share one memory port. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file and memory-port enables. The existing combinational decoder still supplies ALU and operand selects. This block only decides when each datapath element may update.

Parameters:
MEM_TIMEOUT, 16, max cycles o_mem_req may stay high without i_mem_ack before trapping (range 2..255)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_instr  in  32  current IR contents (opcode = [6:0])
i_br_taken  in  1  branch condition result from the comparator/decoder, sampled in EXEC
i_mem_ack  in  1  memory port completion; read data valid in the same cycle
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  write strobe, valid only while o_mem_req=1
o_addr_sel  out  1  0 = PC drives address, 1 = ALU result drives address
o_ir_wren  out  1  IR capture enable
o_pc_wren  out  1  PC update enable
o_pc_sel  out  1  0 = PC+4, 1 = ALU target
o_rd_wren  out  1  register-file write enable
o_insn_vld  out  1  one-cycle retire pulse
o_trap  out  1  sticky trap flag
o_trap_cause  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none
o_state  out  3  current state, for debug

Behaviour:
- Reset:
  - state = RST; class = NONE; timeout counter = 0.
  - All outputs 0; o_state = 3'd0.
  - First rising edge after deassertion: RST -> FETCH (one bubble cycle).
- State encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Output type: outputs are Moore decodes of {state, class}. Exception: o_ir_wren and the ack-qualified enables are combinational on i_mem_ack.
- FETCH:
  - o_mem_req=1, o_addr_sel=0, o_mem_we=0.
  - On i_mem_ack: o_ir_wren=1 in that cycle, then go to DECODE.
  - Without ack: stay in FETCH.
- DECODE: one cycle. Classify opcode into class and register it:
  - 0110011 / 0010011 -> ALU
  - 0000011 -> LOAD
  - 0100011 -> STORE
  - 1100011 -> BRANCH
  - 1101111 / 1100111 -> JUMP
  - 0110111 / 0010111 -> UPPER
  - Any other opcode -> TRAP, cause 01.
- EXEC: one cycle.
  - BRANCH: o_pc_wren=1, o_pc_sel=i_br_taken, o_insn_vld=1, then FETCH.
  - LOAD or STORE: go to MEM.
  - ALU, JUMP, UPPER: go to WB.
- MEM:
  - o_mem_req=1, o_addr_sel=1, o_mem_we=(class==STORE).
  - On ack, STORE: o_pc_wren=1, o_pc_sel=0, o_insn_vld=1, then FETCH.
  - On ack, LOAD: go to WB.
- WB:
  - o_rd_wren=1, o_pc_wren=1, o_insn_vld=1, then FETCH.
  - o_pc_sel = 1 for JUMP, 0 otherwise.
- Timeout:
  - 8-bit counter clears on entry to FETCH or MEM and on any ack.
  - Increments each cycle with o_mem_req=1 and no ack.
  - When count == MEM_TIMEOUT-1 and ack is still absent: go to TRAP, cause 10.
  - Ack in that same cycle wins: normal transition, no trap.
- TRAP:
  - All enables 0; o_trap=1; cause held.
  - Exit only by reset.
- Latency, zero-wait memory: ALU/UPPER/JUMP 4 cycles, BRANCH 3, STORE 4, LOAD 5. Each cycle of ack delay adds one cycle.
- Reset mid-operation: immediate asynchronous return to RST with all outputs 0. A pending o_mem_req drops combinationally.
- Invariants:
  - At most one of o_ir_wren, o_rd_wren is set per cycle.
  - o_insn_vld=1 implies o_pc_wren=1.

Optional Feature:
RV_SEQ_CTRL_PERF_EN:
- Defined: adds o_cycle_cnt[31:0] and o_retire_cnt[31:0].
  - o_cycle_cnt increments every cycle outside RST/TRAP.
  - o_retire_cnt increments on o_insn_vld.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rv_seq_pkg holds:
  - state_t enum (3-bit encoding above)
  - class_t enum (NONE, ALU, LOAD, STORE, BRANCH, JUMP, UPPER)
  - RV32I opcode localparams
  - trap cause constants
- Sub-module rv_seq_timeout: counter with clear/enable inputs and an expired output, parameterised by MEM_TIMEOUT.

Test Plan:
- ADDI x1,x0,5 (0x00500093), ack on first request cycle -> o_state 1,2,3,5,1; o_rd_wren and o_insn_vld high only in the WB cycle; o_pc_sel=0.
- LW x2,0(x1) (0x0000A103), MEM ack delayed 3 cycles -> o_mem_req high 4 cycles with o_addr_sel=1, o_mem_we=0; WB follows; total 8 cycles.
- BEQ (0x00208463) in EXEC -> i_br_taken=1 gives o_pc_sel=1 with o_pc_wren=1 and o_insn_vld=1, no WB; repeat with i_br_taken=0 -> o_pc_sel=0.
- Instruction 0x00000000 -> TRAP after DECODE; o_trap=1, cause 01; i_mem_ack pulses produce no enables.
- MEM_TIMEOUT=4, FETCH with ack never asserted -> TRAP on the 4th request cycle, cause 10; ack on exactly the 4th cycle -> DECODE, no trap.
- SW (0x00112023), i_rst_n low mid-MEM -> o_mem_req and o_mem_we fall immediately; after release: RST, then FETCH, with no o_insn_vld pulse.
